id_ex_reg: RTL and testbench
============================

# id_ex_reg

Pipeline register between decode (ID) and execute (EX) of the five-stage core. It captures decoded operands and register indices, and inserts bubbles on stall or flush. It presents EX-stage `rs1`/`rs2`/`rd`/class fields to the forwarding unit. Its operand muxes consume the forwarding unit's `fwd_A`/`fwd_B` selects to produce the final ALU operands. It also keeps saturating bubble and flush counters for performance reporting.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `CNT_W`, 16, width of each performance counter

Ports:
- `clk`  in  1  clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `hold`  in  1  freeze: keep all registered state (memory wait)
- `stall`  in  1  load-use stall from the hazard unit: insert a bubble
- `flush`  in  1  branch/jump redirect: insert a bubble
- `id_valid`  in  1  ID holds a real instruction
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  decoded register indices
- `id_inst`  in  2  instruction class: 00 no write-back, 01 ALU, 10 load, 11 other write-back
- `id_rs1_data`, `id_rs2_data`  in  XLEN each  register-file read data
- `id_imm`  in  XLEN  immediate
- `id_use_imm`  in  1  operand B takes the immediate
- `fwd_A`, `fwd_B`  in  2 each  forwarding selects: 00 register, 01 EX/MEM ALU result, 10 MEM result, 11 WB result
- `exmem_alu`, `mem_result`, `wb_result`  in  XLEN each  forwarding sources
- `ex_valid`  out  1  EX holds a real instruction
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5 each  registered indices, to the forwarding unit
- `ex_inst`  out  2  registered class
- `ex_op_a`, `ex_op_b`  out  XLEN each  forwarded ALU operands (combinational)
- `ex_store_data`  out  XLEN  forwarded rs2 value, unaffected by `id_use_imm`
- `bubble_cnt`, `flush_cnt`  out  CNT_W each  saturating counters

## Operation
- Per-edge priority: `rst` > `hold` > `flush` > `stall` > load.
- `rst`: all registered fields and counters go to 0. Every output therefore resets to 0, and operands come from the zeroed data registers.
- `hold`: every register keeps its value, including the counters. `flush`/`stall` are ignored for that edge.
- Bubble (`flush` or `stall`):
  - `ex_valid`, `ex_rs1`, `ex_rs2`, `ex_rd`, `ex_inst` go to 0.
  - Data registers go to 0.
  - `flush` increments `flush_cnt`; `stall` alone increments `bubble_cnt`; both asserted increments only `flush_cnt`.
- Load: all fields are captured from ID, with these normalisations:
  - `id_valid`=0 loads a bubble; no counter changes.
  - `id_inst`=00 forces `ex_rd`=0, so the forwarding unit's nonzero-rd check suppresses forwarding.
  - `id_rd`=0 with class ≠00 forces `ex_inst`=00 (writes to x0 are never forwarded).
- Counters saturate at all-ones and never wrap.
- Operand A: the register value or forwarding source selected by `fwd_A`.
- Operand B: the `fwd_B`-selected value, or the registered immediate when `id_use_imm` was captured as 1.
- `ex_store_data` is always the `fwd_B`-selected value.

## Timing
- Latency 1 cycle from ID inputs to registered EX fields.
- `ex_op_a`, `ex_op_b`, `ex_store_data` are combinational from registered state and `fwd_*`/source inputs, with zero cycles of added latency.
- A single-cycle `stall` yields exactly one bubble in EX. The hazard unit holds IF/ID, so the stalled instruction loads on the next non-stall edge.
- `rst` asserted mid-stream clears state on that edge regardless of `hold`. The first load is possible on the edge after `rst` deasserts.
- `hold` lasting N cycles leaves EX contents and counters unchanged for N edges. Operands keep tracking their combinational inputs.

## Test plan
- Reset: drive `rst`=1 for 2 cycles with ID inputs nonzero -> all outputs 0; `bubble_cnt`=`flush_cnt`=0.
- Load and forward: load `rs1`=3, `rs2`=4, `rd`=5, class 01, `rs1_data`=0x11, `rs2_data`=0x22. Sweep `fwd_A` 00/01/10/11 with `exmem_alu`=0xA, `mem_result`=0xB, `wb_result`=0xC -> `ex_op_a` = 0x11, 0xA, 0xB, 0xC.
- Immediate path: `id_use_imm`=1, `imm`=0x40, `fwd_B`=01, `exmem_alu`=0xA -> `ex_op_b`=0x40 and `ex_store_data`=0xA.
- Bubbles: one cycle of `stall`, then `flush`+`stall` together -> EX fields 0 both cycles; `bubble_cnt`=1, `flush_cnt`=1.
- x0 rule: load `rd`=0 with class 01 -> `ex_inst`=00. Load class 00 with `rd`=7 -> `ex_rd`=0.
- Hold and saturation: `hold`=1 with `flush`=1 for 3 cycles -> EX fields and `flush_cnt` unchanged. Preset `CNT_W`=2, apply 5 stalls -> `bubble_cnt`=3.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with bubble insertion, operand forwarding muxes and perf counters.
// Latency: 1 cycle ID -> EX fields; operands combinational from registered state and fwd selects.
// Backpressure: hold freezes all state; stall/flush load a bubble; no ready handshake.
module id_ex_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [1:0]       id_inst,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_use_imm,
    input  logic [1:0]       fwd_A,
    input  logic [1:0]       fwd_B,
    input  logic [XLEN-1:0]  exmem_alu,
    input  logic [XLEN-1:0]  mem_result,
    input  logic [XLEN-1:0]  wb_result,
    output logic             ex_valid,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [1:0]       ex_inst,
    output logic [XLEN-1:0]  ex_op_a,
    output logic [XLEN-1:0]  ex_op_b,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic            use_imm_q;
    logic [XLEN-1:0] fwd_a_val;
    logic [XLEN-1:0] fwd_b_val;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_rd      <= '0;
            ex_inst    <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            use_imm_q  <= 1'b0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (!hold) begin
            if (flush || stall || !id_valid) begin
                ex_valid   <= 1'b0;
                ex_rs1     <= '0;
                ex_rs2     <= '0;
                ex_rd      <= '0;
                ex_inst    <= '0;
                rs1_data_q <= '0;
                rs2_data_q <= '0;
                imm_q      <= '0;
                use_imm_q  <= 1'b0;
            end else begin
                ex_valid   <= 1'b1;
                ex_rs1     <= id_rs1;
                ex_rs2     <= id_rs2;
                // No write-back means no rd, so the forwarding unit's rd!=0 check blocks it
                ex_rd      <= (id_inst == 2'b00) ? 5'd0 : id_rd;
                ex_inst    <= (id_rd == 5'd0) ? 2'b00 : id_inst;
                rs1_data_q <= id_rs1_data;
                rs2_data_q <= id_rs2_data;
                imm_q      <= id_imm;
                use_imm_q  <= id_use_imm;
            end
            if (flush)
                flush_cnt <= sat_inc(flush_cnt);
            else if (stall)
                bubble_cnt <= sat_inc(bubble_cnt);
        end
    end

    always_comb begin
        case (fwd_A)
            2'b00:   fwd_a_val = rs1_data_q;
            2'b01:   fwd_a_val = exmem_alu;
            2'b10:   fwd_a_val = mem_result;
            default: fwd_a_val = wb_result;
        endcase
        case (fwd_B)
            2'b00:   fwd_b_val = rs2_data_q;
            2'b01:   fwd_b_val = exmem_alu;
            2'b10:   fwd_b_val = mem_result;
            default: fwd_b_val = wb_result;
        endcase
    end

    assign ex_op_a       = fwd_a_val;
    assign ex_op_b       = use_imm_q ? imm_q : fwd_b_val;
    assign ex_store_data = fwd_b_val;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg; expectations queued at drive time and popped at each check.
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst, hold, stall, flush, id_valid, id_use_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]  id_inst, fwd_A, fwd_B;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, exmem_alu, mem_result, wb_result;

    logic        ex_valid, ex_valid2;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_rs1_2, ex_rs2_2, ex_rd2;
    logic [1:0]  ex_inst, ex_inst2;
    logic [31:0] ex_op_a, ex_op_b, ex_store_data, ex_op_a2, ex_op_b2, ex_store_data2;
    logic [15:0] bubble_cnt, flush_cnt;
    logic [1:0]  bubble_cnt2, flush_cnt2;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    id_ex_reg #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .hold(hold), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_inst(id_inst), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .fwd_A(fwd_A), .fwd_B(fwd_B),
        .exmem_alu(exmem_alu), .mem_result(mem_result), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_inst(ex_inst), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_store_data(ex_store_data), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation
    id_ex_reg #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .hold(hold), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_inst(id_inst), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .fwd_A(fwd_A), .fwd_B(fwd_B),
        .exmem_alu(exmem_alu), .mem_result(mem_result), .wb_result(wb_result),
        .ex_valid(ex_valid2), .ex_rs1(ex_rs1_2), .ex_rs2(ex_rs2_2), .ex_rd(ex_rd2),
        .ex_inst(ex_inst2), .ex_op_a(ex_op_a2), .ex_op_b(ex_op_b2),
        .ex_store_data(ex_store_data2), .bubble_cnt(bubble_cnt2), .flush_cnt(flush_cnt2)
    );

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no expectation queued, observed %0h", tag, obs);
            return;
        end
        e = exp_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [1:0] cls, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic use_imm);
        id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_inst = cls;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_use_imm = use_imm;
    endtask

    initial begin
        logic [31:0] fwd_exp [4];
        fwd_exp[0] = 32'h11; fwd_exp[1] = 32'hA; fwd_exp[2] = 32'hB; fwd_exp[3] = 32'hC;

        rst = 1'b1; hold = 1'b0; stall = 1'b0; flush = 1'b0;
        fwd_A = 2'b00; fwd_B = 2'b00;
        exmem_alu = 32'hA; mem_result = 32'hB; wb_result = 32'hC;
        load(5'd1, 5'd2, 5'd3, 2'b01, 32'hDEAD, 32'hBEEF, 32'h1234, 1'b0);

        // Reset with nonzero ID inputs
        push(0); push(0); push(0); push(0); push(0); push(0); push(0); push(0); push(0);
        step(); step();
        chk("rst_valid", 32'(ex_valid));
        chk("rst_rs1", 32'(ex_rs1));
        chk("rst_rs2", 32'(ex_rs2));
        chk("rst_rd", 32'(ex_rd));
        chk("rst_inst", 32'(ex_inst));
        chk("rst_op_a", ex_op_a);
        chk("rst_op_b", ex_op_b);
        chk("rst_bubble", 32'(bubble_cnt));
        chk("rst_flush", 32'(flush_cnt));

        // Load and forward sweep
        rst = 1'b0;
        load(5'd3, 5'd4, 5'd5, 2'b01, 32'h11, 32'h22, 32'h40, 1'b0);
        push(1); push(3); push(4); push(5); push(1);
        step();
        chk("ld_valid", 32'(ex_valid));
        chk("ld_rs1", 32'(ex_rs1));
        chk("ld_rs2", 32'(ex_rs2));
        chk("ld_rd", 32'(ex_rd));
        chk("ld_inst", 32'(ex_inst));
        for (int s = 0; s < 4; s++) begin
            fwd_A = 2'(s);
            push(fwd_exp[s]);
            #1;
            chk($sformatf("fwd_a_%0d", s), ex_op_a);
        end
        fwd_A = 2'b00;
        push(32'h22); push(32'h22);
        #1;
        chk("reg_op_b", ex_op_b);
        chk("reg_store", ex_store_data);

        // Immediate path
        id_use_imm = 1'b1;
        step();
        fwd_B = 2'b01;
        push(32'h40); push(32'hA);
        #1;
        chk("imm_op_b", ex_op_b);
        chk("imm_store", ex_store_data);
        fwd_B = 2'b00;

        // Single stall, then flush+stall
        stall = 1'b1;
        push(0); push(0); push(0); push(0); push(1); push(0);
        step();
        chk("stall_valid", 32'(ex_valid));
        chk("stall_rd", 32'(ex_rd));
        chk("stall_inst", 32'(ex_inst));
        chk("stall_op_a", ex_op_a);
        chk("stall_bubble", 32'(bubble_cnt));
        chk("stall_flush", 32'(flush_cnt));
        flush = 1'b1;
        push(0); push(0); push(0); push(1); push(1);
        step();
        chk("fl_valid", 32'(ex_valid));
        chk("fl_rs1", 32'(ex_rs1));
        chk("fl_op_b", ex_op_b);
        chk("fl_bubble", 32'(bubble_cnt));
        chk("fl_flush", 32'(flush_cnt));
        stall = 1'b0; flush = 1'b0;

        // x0 rules
        load(5'd1, 5'd2, 5'd0, 2'b01, 32'h5, 32'h6, 32'h0, 1'b0);
        push(1); push(0); push(0);
        step();
        chk("x0_valid", 32'(ex_valid));
        chk("x0_inst", 32'(ex_inst));
        chk("x0_rd", 32'(ex_rd));
        load(5'd1, 5'd2, 5'd7, 2'b00, 32'h5, 32'h6, 32'h0, 1'b0);
        push(0); push(0);
        step();
        chk("nowb_rd", 32'(ex_rd));
        chk("nowb_inst", 32'(ex_inst));

        // Load class, then id_valid=0 loads a bubble with no counter change
        load(5'd8, 5'd9, 5'd9, 2'b10, 32'h77, 32'h88, 32'h0, 1'b0);
        push(9); push(2); push(32'h77);
        step();
        chk("lw_rd", 32'(ex_rd));
        chk("lw_inst", 32'(ex_inst));
        chk("lw_op_a", ex_op_a);
        id_valid = 1'b0;
        push(0); push(0); push(1); push(1);
        step();
        chk("inv_valid", 32'(ex_valid));
        chk("inv_rd", 32'(ex_rd));
        chk("inv_bubble", 32'(bubble_cnt));
        chk("inv_flush", 32'(flush_cnt));

        // Hold overrides flush for 3 edges; operands keep tracking sources
        load(5'd10, 5'd11, 5'd6, 2'b01, 32'h99, 32'hAA, 32'h0, 1'b0);
        step();
        hold = 1'b1; flush = 1'b1; fwd_A = 2'b01;
        for (int i = 0; i < 3; i++) begin
            exmem_alu = 32'h100 + 32'(i);
            push(1); push(6); push(1); push(1); push(32'h100 + 32'(i));
            step();
            chk("hold_valid", 32'(ex_valid));
            chk("hold_rd", 32'(ex_rd));
            chk("hold_inst", 32'(ex_inst));
            chk("hold_flush", 32'(flush_cnt));
            chk("hold_op_a", ex_op_a);
        end
        flush = 1'b0; fwd_A = 2'b00;

        // Reset wins over hold
        rst = 1'b1;
        push(0); push(0); push(0); push(0);
        step();
        chk("rsthold_valid", 32'(ex_valid));
        chk("rsthold_rd", 32'(ex_rd));
        chk("rsthold_bubble", 32'(bubble_cnt));
        chk("rsthold_flush", 32'(flush_cnt));
        rst = 1'b0; hold = 1'b0;

        // Saturation: 16-bit counter counts, 2-bit counter sticks at 3
        stall = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push(32'(i));
            push((i > 3) ? 32'd3 : 32'(i));
            step();
            chk("sat_wide", 32'(bubble_cnt));
            chk("sat_narrow", 32'(bubble_cnt2));
        end
        stall = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
